// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin memory arbiter.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_cmd_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches from ptr+1 upward (wrapping) for
// the first requester that is both requesting and not masked.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  int cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found) begin
        cand = (int'(ptr) + k) % NUM_REQ;
        if (req[cand] && mask[cand]) begin
          found     = 1'b1;
          gnt[cand] = 1'b1;
          idx       = IDX_W'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ requesters.
// Optional MEM_ARB_TURNAROUND_EN inserts an idle cycle on every read/write direction change.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  mem_arb_state_e     state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   tag;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               win_found;
  logic               transfer;
  mem_cmd_t           sel_cmd;

`ifdef MEM_ARB_TURNAROUND_EN
  // Only requesters matching the direction already on the bus may follow it.
  always_comb begin
    mask = '1;
    if (state == ACCESS) mask = ~(req_we ^ {NUM_REQ{mem_wr}});
  end
`else
  assign mask = '1;
`endif

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req  (req),
    .mask (mask),
    .ptr  (ptr),
    .gnt  (arb_gnt),
    .idx  (win_idx),
    .found(win_found)
  );

  assign gnt      = reset_n ? arb_gnt : '0;
  assign transfer = reset_n && win_found;

  always_comb begin
    sel_cmd.we    = req_we[win_idx];
    sel_cmd.addr  = MEM_ADDR_W'(req_addr[win_idx*ADDR_W +: ADDR_W]);
    sel_cmd.wdata = MEM_DATA_W'(req_wdata[win_idx*DATA_W +: DATA_W]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= IDX_W'(NUM_REQ - 1);
      tag       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
    end else if (transfer) begin
      state     <= ACCESS;
      ptr       <= win_idx;
      tag       <= win_idx;
      mem_addr  <= ADDR_W'(sel_cmd.addr);
      mem_wdata <= DATA_W'(sel_cmd.wdata);
      mem_rd    <= ~sel_cmd.we;
      mem_wr    <= sel_cmd.we;
    end else begin
      state  <= IDLE;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
    end
  end

  // Read data is captured at the edge closing the ACCESS cycle and returned to its tag owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= '0;
      if (state == ACCESS && mem_rd) begin
        rvalid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << tag;
        rdata  <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed commands push expected grants,
// bus accesses and read returns; a negedge monitor pops and compares them.
module tb_mem_arbiter;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          gap;
  } bus_exp_t;

  typedef struct {
    logic [3:0]  vec;
    logic [15:0] data;
  } rd_exp_t;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [15:0] rdata;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [0:65535];

  bus_exp_t   bus_q[$];
  rd_exp_t    rd_q[$];
  logic [3:0] gnt_q[$];
  bus_exp_t   mon_bus;
  rd_exp_t    mon_rd;
  logic [3:0] mon_gnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_bus_cyc = -100;
  int rd_acc_cyc[4];

  mem_arbiter #(
    .NUM_REQ(4),
    .ADDR_W (16),
    .DATA_W (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port bench memory: synchronous write, combinational read.
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_rd ? mem[mem_addr] : 16'h0000;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_bus(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input int gap);
    bus_exp_t e;
    e.rd = rd; e.wr = wr; e.addr = a; e.wdata = d; e.gap = gap;
    bus_q.push_back(e);
  endtask

  task automatic push_rd(input logic [3:0] v, input logic [15:0] d);
    rd_exp_t e;
    e.vec = v; e.data = d;
    rd_q.push_back(e);
  endtask

  task automatic set_cmd(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
    req_we[i]            = we;
    req_addr[i*16 +: 16] = a;
    req_wdata[i*16 +: 16] = d;
  endtask

  // Drops each requester's req after its acceptance edge; bounded by budget cycles.
  task automatic applyStimulus(input int budget);
    logic [3:0] acc;
    int n;
    n = 0;
    while (req != 4'b0000 && n < budget) begin
      @(negedge clk);
      acc = req & gnt;
      @(posedge clk);
      #1;
      req = req & ~acc;
      n++;
    end
    if (req != 4'b0000) begin
      checkOutput("accept_timeout", 32'(req), 32'h0);
      req = 4'b0000;
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (rvalid != 4'b0000) begin
        if (rd_q.size() == 0) begin
          checkOutput("rvalid_unexpected", 32'(rvalid), 32'h0);
        end else begin
          mon_rd = rd_q.pop_front();
          checkOutput("rvalid", 32'(rvalid), 32'(mon_rd.vec));
          checkOutput("rdata", 32'(rdata), 32'(mon_rd.data));
          for (int j = 0; j < 4; j++)
            if (mon_rd.vec[j]) checkOutput("rd_latency", 32'(cyc - rd_acc_cyc[j]), 32'd2);
        end
      end
      if (mem_rd || mem_wr) begin
        if (bus_q.size() == 0) begin
          checkOutput("bus_unexpected", {30'd0, mem_rd, mem_wr}, 32'h0);
        end else begin
          mon_bus = bus_q.pop_front();
          checkOutput("mem_rd", 32'(mem_rd), 32'(mon_bus.rd));
          checkOutput("mem_wr", 32'(mem_wr), 32'(mon_bus.wr));
          checkOutput("mem_addr", 32'(mem_addr), 32'(mon_bus.addr));
          if (mon_bus.wr) checkOutput("mem_wdata", 32'(mem_wdata), 32'(mon_bus.wdata));
          if (mon_bus.gap >= 0) checkOutput("bus_gap", 32'(cyc - last_bus_cyc), 32'(mon_bus.gap));
        end
        last_bus_cyc = cyc;
      end
      if (gnt != 4'b0000) begin
        if (gnt_q.size() == 0) begin
          checkOutput("gnt_unexpected", 32'(gnt), 32'h0);
        end else begin
          mon_gnt = gnt_q.pop_front();
          checkOutput("gnt", 32'(gnt), 32'(mon_gnt));
        end
        for (int j = 0; j < 4; j++)
          if (gnt[j] && !req_we[j]) rd_acc_cyc[j] = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mem[16'h0001] = 16'h1111;
    mem[16'h0003] = 16'h3333;
    for (int i = 0; i < 4; i++) mem[16'h0100 + i] = 16'h5100 + 16'(i);
    reset_n   = 1'b0;
    req       = 4'b0000;
    req_we    = 4'b0000;
    req_addr  = '0;
    req_wdata = '0;

    // Reset with all requesters asserting: nothing may be granted or strobed.
    for (int i = 0; i < 4; i++) set_cmd(i, 1'b0, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
    req = 4'b1111;
    repeat (2) @(negedge clk);
    checkOutput("reset_gnt", 32'(gnt), 32'h0);
    checkOutput("reset_mem_rd", 32'(mem_rd), 32'h0);
    checkOutput("reset_mem_wr", 32'(mem_wr), 32'h0);
    checkOutput("reset_rvalid", 32'(rvalid), 32'h0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("reset_mem_wdata", 32'(mem_wdata), 32'h0);
    checkOutput("reset_rdata", 32'(rdata), 32'h0);

    // Fairness: continuous requests from all four give order 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      gnt_q.push_back(4'b0001 << (k % 4));
      push_bus(1'b1, 1'b0, 16'h0100 + 16'(k % 4), 16'h0000, (k == 0) ? -1 : 1);
      push_rd(4'b0001 << (k % 4), 16'h5100 + 16'(k % 4));
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 req = 4'b0000;
    repeat (3) @(posedge clk);
    #1;

    // Requester 2 writes 0xBEEF to 0x0010, then reads it back.
    gnt_q.push_back(4'b0100);
    push_bus(1'b0, 1'b1, 16'h0010, 16'hBEEF, -1);
    set_cmd(2, 1'b1, 16'h0010, 16'hBEEF);
    req = 4'b0100;
    applyStimulus(10);
    gnt_q.push_back(4'b0100);
    push_bus(1'b1, 1'b0, 16'h0010, 16'h0000, -1);
    push_rd(4'b0100, 16'hBEEF);
    set_cmd(2, 1'b0, 16'h0010, 16'h0000);
    req = 4'b0100;
    applyStimulus(10);
    repeat (3) @(posedge clk);
    #1;

    // Requester 0 write moves the pointer so 1 then 3 read back-to-back.
    gnt_q.push_back(4'b0001);
    push_bus(1'b0, 1'b1, 16'h0020, 16'h0055, -1);
    set_cmd(0, 1'b1, 16'h0020, 16'h0055);
    req = 4'b0001;
    applyStimulus(10);
    gnt_q.push_back(4'b0010);
    gnt_q.push_back(4'b1000);
    push_bus(1'b1, 1'b0, 16'h0001, 16'h0000, -1);
    push_bus(1'b1, 1'b0, 16'h0003, 16'h0000, 1);
    push_rd(4'b0010, 16'h1111);
    push_rd(4'b1000, 16'h3333);
    set_cmd(1, 1'b0, 16'h0001, 16'h0000);
    set_cmd(3, 1'b0, 16'h0003, 16'h0000);
    req = 4'b1010;
    applyStimulus(10);
    repeat (3) @(posedge clk);
    #1;

    // Write then read of the same address by different requesters.
    gnt_q.push_back(4'b0001);
    gnt_q.push_back(4'b0010);
    push_bus(1'b0, 1'b1, 16'h0030, 16'h00AA, -1);
`ifdef MEM_ARB_TURNAROUND_EN
    push_bus(1'b1, 1'b0, 16'h0030, 16'h0000, 2);
`else
    push_bus(1'b1, 1'b0, 16'h0030, 16'h0000, 1);
`endif
    push_rd(4'b0010, 16'h00AA);
    set_cmd(0, 1'b1, 16'h0030, 16'h00AA);
    set_cmd(1, 1'b0, 16'h0030, 16'h0000);
    req = 4'b0011;
    applyStimulus(10);
    repeat (3) @(posedge clk);
    #1;

    // Reset during the ACCESS cycle of a read: strobe drops, no return follows.
    gnt_q.push_back(4'b1000);
    set_cmd(3, 1'b0, 16'h0003, 16'h0000);
    req = 4'b1000;
    @(negedge clk);
    @(posedge clk);
    #1 req = 4'b0000;
    checkOutput("midrd_mem_rd_before", 32'(mem_rd), 32'h1);
    reset_n = 1'b0;
    req = 4'b1111;
    #1;
    checkOutput("midrd_mem_rd_after", 32'(mem_rd), 32'h0);
    checkOutput("midrd_gnt", 32'(gnt), 32'h0);
    checkOutput("midrd_rvalid", 32'(rvalid), 32'h0);
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) @(negedge clk);

    checkOutput("gnt_q_empty", 32'(gnt_q.size()), 32'h0);
    checkOutput("bus_q_empty", 32'(bus_q.size()), 32'h0);
    checkOutput("rd_q_empty", 32'(rd_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares one 16-bit single-port bench memory (address/data bus with `rd`/`wr` strobes) among `NUM_REQ` requesters. It accepts read/write commands through a per-requester valid/grant handshake and issues at most one memory access per cycle. It returns read data with a per-requester valid pulse. It sits between the test-side agents and the memory interface's tester-side signals, and owns the bus strobes exclusively.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.

- `clk`  input  1  clock, all logic on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `req`  input  NUM_REQ  per-requester command valid.
- `req_we`  input  NUM_REQ  1 = write, 0 = read.
- `req_addr`  input  NUM_REQ*ADDR_W  packed addresses, requester i at `[i*ADDR_W +: ADDR_W]`.
- `req_wdata`  input  NUM_REQ*DATA_W  packed write data.
- `gnt`  output  NUM_REQ  combinational grant, one-hot or zero.
- `rvalid`  output  NUM_REQ  one-cycle read-return pulse, one-hot or zero.
- `rdata`  output  DATA_W  read data, shared, valid when any `rvalid`.
- `mem_addr`  output  ADDR_W  memory address.
- `mem_rd`  output  1  memory read strobe.
- `mem_wr`  output  1  memory write strobe; drives bus data when high.
- `mem_wdata`  output  DATA_W  write data to bus driver.
- `mem_rdata`  input  DATA_W  resolved memory data bus.

## Operation
- Transfer: requester i's command is accepted at a rising edge where `req[i] && gnt[i]`. The requester holds `req`, `req_we`, `req_addr` and `req_wdata` stable until acceptance.
- `gnt` is combinational from `req` and the priority pointer. At most one bit is set. A grant is never given without the matching `req`.
- Round-robin priority:
  - Search starts at `ptr+1` (mod `NUM_REQ`).
  - On each transfer, `ptr` becomes the winner index.
  - `ptr` is unchanged on cycles with no transfer.
- Issue stage (state ACCESS): the accepted command is registered into `mem_addr`, `mem_wdata`, `mem_rd = ~we`, `mem_wr = we`, plus a tag holding the requester index.
  - If no transfer occurs, the state goes to IDLE: `mem_rd = mem_wr = 0`; `mem_addr` and `mem_wdata` hold their last values.
- States are IDLE and ACCESS:
  - IDLE→ACCESS on transfer.
  - ACCESS→ACCESS on transfer (back-to-back).
  - ACCESS→IDLE otherwise.
- Read return: in an ACCESS cycle with `mem_rd`, `mem_rdata` is sampled at the closing edge. The following cycle has `rdata` = sample and `rvalid[tag]` = 1 for exactly one cycle.
- Writes produce no response. Write completion is implied by `gnt`.
- `mem_rd` and `mem_wr` are never both high.
- Reset (async, any time):
  - Outputs: `mem_rd`, `mem_wr`, `rvalid` = 0; `mem_addr`, `mem_wdata`, `rdata` = 0.
  - `ptr` = `NUM_REQ-1`, so requester 0 has first priority; state = IDLE; in-flight read returns are discarded.
  - `gnt` = 0 while `reset_n` is low.

## Timing
- Latency:
  - Acceptance edge E: strobe is on the bus in cycle E..E+1.
  - Read data is sampled at E+1.
  - `rvalid` is high in cycle E+1..E+2.
- Read latency is 2 cycles from acceptance to `rvalid`.
- Throughput is one access per cycle with no turnaround (see Configuration).
- Simultaneous events:
  - A new transfer at the same edge as a read sample is legal. `rvalid` for the old read and the strobe for the new command coexist.
  - `rvalid` and a new `gnt` to the same requester in the same cycle are legal.

## Configuration
- `MEM_ARB_TURNAROUND_EN`: inserts a bus-turnaround bubble.
  - Defined: in an ACCESS cycle, `gnt` is forced low for every requester whose `req_we` differs from the command currently on the bus. This yields one IDLE cycle between a write and a read, and vice versa. Same-direction back-to-back accesses are unaffected. Round-robin order is preserved: the held requester wins the next cycle if it is still next in priority.
  - Undefined: no bubble; direction may change every cycle.

## Structure
- `mem_arb_pkg`:
  - Constants: `MEM_ADDR_W = 16`, `MEM_DATA_W = 16`.
  - Typedef `mem_cmd_t`: packed struct {`we`, `addr`, `wdata`}.
  - Enum `mem_arb_state_e`: {IDLE, ACCESS}.
- Sub-module `rr_arbiter`: combinational round-robin pick from `req`, a mask and `ptr`, producing a one-hot grant and an encoded index. `mem_arbiter` owns the pointer register, the issue registers and the read-return register.

## Test plan
- Reset: hold `reset_n` low with `req = 4'b1111` → `gnt = 0`, all strobes 0. After release, first `gnt = 4'b0001`.
- Single write then read: requester 2 writes 0xBEEF to 0x0010, then reads 0x0010 → `mem_wr` for one cycle with `mem_addr = 0x0010`; later `rvalid = 4'b0100`, `rdata = 0xBEEF` exactly 2 cycles after read acceptance.
- Fairness: all four requesters hold `req` continuously for 8 transfers → grant order 0,1,2,3,0,1,2,3 with `mem_rd`/`mem_wr` high every cycle (macro off).
- Back-to-back reads from requesters 1 and 3 (addresses 0x0001, 0x0003, preloaded 0x1111, 0x3333) → `rvalid` 4'b0010 then 4'b1000 on consecutive cycles with matching `rdata`.
- Turnaround (macro on): requester 0 writes 0x00AA, requester 1 reads the same address next → one cycle with `mem_rd = mem_wr = 0` between them, `rdata = 0x00AA`. With the macro off, there is no gap.
- Mid-read reset: assert `reset_n` low in the ACCESS cycle of a read → `mem_rd` drops immediately and no `rvalid` appears after release.
